xadc_drp_sampler: RTL and testbench

Drives the XADC dynamic reconfiguration port (DRP) for one fixed channel. On each end-of-conversion pulse it issues a single DRP read and waits for data-ready, with a timeout. It extracts the 12-bit conversion result and box-car averages 2^AVG_LOG2 samples. The averaged 8-bit level feeds the LED PWM compare input.

---
 rtl/xadc_pkg.sv | 18 +
 rtl/sample_avg.sv | 59 +++++
 rtl/xadc_drp_sampler.sv | 111 +++++++++++
 tb/tb_xadc_drp_sampler.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared definitions for the XADC DRP sampler.
//   xadc_state_t : read sequencer states (IDLE, REQ, WAIT)
//   XADC_RES_W   : width of one XADC conversion result
//   VPVN, TEMP   : DRP addresses of the dedicated input and the temperature sensor
package xadc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } xadc_state_t;

    localparam int XADC_RES_W = 12;

    localparam logic [6:0] VPVN = 7'h03;
    localparam logic [6:0] TEMP = 7'h00;

endpackage

// File: rtl/sample_avg.sv
// Box-car averager for XADC results.
// Accumulates 2^AVG_LOG2 samples. On the sample that completes a block it
// publishes the top 8 bits of the 12-bit mean and pulses level_valid. The
// result is registered on the same edge that accepts the completing sample.
//   clk, rst_n    : clock, synchronous active-low reset
//   sample        : 12-bit conversion result (qualified by sample_valid)
//   sample_valid  : one-cycle strobe, sample is accepted on this edge
//   level         : averaged level, held between updates
//   level_valid   : one-cycle pulse when level updates
module sample_avg
    import xadc_pkg::*;
#(
    parameter int AVG_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [XADC_RES_W-1:0] sample,
    input  logic                  sample_valid,
    output logic [7:0]            level,
    output logic                  level_valid
);

    localparam int ACC_W = XADC_RES_W + AVG_LOG2;
    // Keep the counter at least one bit wide so AVG_LOG2 = 0 stays legal.
    localparam int CNT_W = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       level_nxt;

    assign sum = acc + ACC_W'(sample);
    // mean = sum >> AVG_LOG2 fits in 12 bits; level is its top byte.
    assign level_nxt = 8'(sum >> (AVG_LOG2 + 4));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc         <= '0;
            cnt         <= '0;
            level       <= '0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            if (sample_valid) begin
                if (cnt == CNT_LAST) begin
                    level       <= level_nxt;
                    level_valid <= 1'b1;
                    acc         <= '0;
                    cnt         <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/xadc_drp_sampler.sv
// XADC DRP read sequencer for one fixed channel.
// Each end-of-conversion pulse seen in IDLE launches one DRP read; the result
// in drp_do[15:4] is captured on data-ready, or the read is abandoned after
// TIMEOUT wait cycles and the sticky timeout_err is set. Captured results feed
// a box-car averager whose 8-bit level drives the LED PWM compare.
//   clk, rst_n    : clock, synchronous active-low reset
//   eoc_in        : end-of-conversion pulse (ignored unless IDLE)
//   drp_den       : one-cycle read strobe
//   drp_daddr     : constant CHANNEL
//   drp_dwe       : always 0 (read-only)
//   drp_drdy      : read data ready (honoured only in WAIT)
//   drp_do        : read data, result in [15:4]
//   sample        : last raw result, sample_valid pulses on update
//   level         : averaged level, level_valid pulses on update
//   timeout_err   : sticky, set on any abandoned read
//   state_dbg     : current sequencer state
//
// DRP handshake: drp_den is high for exactly one cycle per read; the read
// completes on the first cycle drp_drdy is high while the FSM is in WAIT.
// drp_drdy in any other state is a stray and is discarded.
module xadc_drp_sampler
    import xadc_pkg::*;
#(
    parameter logic [6:0] CHANNEL  = VPVN,
    parameter int         AVG_LOG2 = 4,
    parameter int         TIMEOUT  = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  eoc_in,
    output logic                  drp_den,
    output logic [6:0]            drp_daddr,
    output logic                  drp_dwe,
    input  logic                  drp_drdy,
    input  logic [15:0]           drp_do,
    output logic [XADC_RES_W-1:0] sample,
    output logic                  sample_valid,
    output logic [7:0]            level,
    output logic                  level_valid,
    output logic                  timeout_err,
    output xadc_state_t           state_dbg
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    xadc_state_t state;
    xadc_state_t state_nxt;
    logic [15:0] to_cnt;
    logic        rd_done;
    logic        rd_timeout;
    logic        unused_low_bits;

    assign drp_daddr       = CHANNEL;
    assign drp_dwe         = 1'b0;
    assign state_dbg       = state;
    assign unused_low_bits = ^drp_do[3:0];

    always_comb begin
        state_nxt  = state;
        rd_done    = 1'b0;
        rd_timeout = 1'b0;
        case (state)
            IDLE: if (eoc_in) state_nxt = REQ;
            REQ:  state_nxt = WAIT;
            WAIT: begin
                // drdy takes priority over the terminal count.
                if (drp_drdy) begin
                    rd_done   = 1'b1;
                    state_nxt = IDLE;
                end else if (to_cnt == TO_LAST) begin
                    rd_timeout = 1'b1;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            to_cnt       <= '0;
            drp_den      <= 1'b0;
            sample       <= '0;
            sample_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            // Registered strobe: high exactly during the REQ cycle.
            drp_den      <= (state_nxt == REQ);
            sample_valid <= rd_done;
            if (rd_done) sample <= drp_do[15:4];
            if (rd_timeout) timeout_err <= 1'b1;
            if (state == REQ) to_cnt <= '0;
            else if (state == WAIT) to_cnt <= to_cnt + 16'd1;
        end
    end

    // Fed from the raw DRP data so level lands in the same cycle as sample.
    sample_avg #(
        .AVG_LOG2(AVG_LOG2)
    ) u_avg (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample      (drp_do[15:4]),
        .sample_valid(rd_done),
        .level       (level),
        .level_valid (level_valid)
    );

endmodule

// File: tb/tb_xadc_drp_sampler.sv
// Bench for xadc_drp_sampler: two instances share stimulus, one with no
// averaging (AVG_LOG2=0) and one averaging four samples (AVG_LOG2=2), both
// with TIMEOUT=8. Expected samples/levels are queued when drdy is driven and
// popped when the DUTs pulse their valid outputs.
module tb_xadc_drp_sampler;
    import xadc_pkg::*;

    localparam int TO = 8;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        eoc_in;
    logic        drp_drdy;
    logic [15:0] drp_do;

    logic        den0, dwe0, sv0, lv0, err0;
    logic [6:0]  daddr0;
    logic [11:0] sample0;
    logic [7:0]  level0;
    xadc_state_t st0;

    logic        den2, dwe2, sv2, lv2, err2;
    logic [6:0]  daddr2;
    logic [11:0] sample2;
    logic [7:0]  level2;
    xadc_state_t st2;

    xadc_drp_sampler #(.CHANNEL(VPVN), .AVG_LOG2(0), .TIMEOUT(TO)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .eoc_in(eoc_in),
        .drp_den(den0), .drp_daddr(daddr0), .drp_dwe(dwe0),
        .drp_drdy(drp_drdy), .drp_do(drp_do),
        .sample(sample0), .sample_valid(sv0),
        .level(level0), .level_valid(lv0),
        .timeout_err(err0), .state_dbg(st0)
    );

    xadc_drp_sampler #(.CHANNEL(VPVN), .AVG_LOG2(2), .TIMEOUT(TO)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .eoc_in(eoc_in),
        .drp_den(den2), .drp_daddr(daddr2), .drp_dwe(dwe2),
        .drp_drdy(drp_drdy), .drp_do(drp_do),
        .sample(sample2), .sample_valid(sv2),
        .level(level2), .level_valid(lv2),
        .timeout_err(err2), .state_dbg(st2)
    );

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // ---------------- scoreboard ----------------
    logic [11:0] exp_s0_q[$];
    logic [11:0] exp_s2_q[$];
    logic [7:0]  exp_l0_q[$];
    logic [7:0]  exp_l2_q[$];
    int          acc2 = 0;
    int          cnt2 = 0;
    logic [11:0] last_sample = '0;
    logic        exp_err = 1'b0;
    int          den_cnt = 0;

    task automatic push_read(input logic [11:0] val);
        exp_s0_q.push_back(val);
        exp_s2_q.push_back(val);
        exp_l0_q.push_back(val[11:4]);
        acc2 += int'(val);
        cnt2++;
        if (cnt2 == 4) begin
            exp_l2_q.push_back(8'((acc2 / 4) / 16));
            acc2 = 0;
            cnt2 = 0;
        end
        last_sample = val;
    endtask

    always @(negedge clk) begin
        if (den0) den_cnt++;
        if (sv0) begin
            if (exp_s0_q.size() == 0) check("sample0_unexpected", 1, 0);
            else check("sample0", sample0, exp_s0_q.pop_front());
        end
        if (sv2) begin
            if (exp_s2_q.size() == 0) check("sample2_unexpected", 1, 0);
            else check("sample2", sample2, exp_s2_q.pop_front());
        end
        if (lv0) begin
            if (exp_l0_q.size() == 0) check("level0_unexpected", 1, 0);
            else check("level0", level0, exp_l0_q.pop_front());
        end
        if (lv2) begin
            if (exp_l2_q.size() == 0) check("level2_unexpected", 1, 0);
            else check("level2", level2, exp_l2_q.pop_front());
        end
    end

    // ---------------- drivers ----------------
    // eoc pulse, then drdy 'lat' cycles into WAIT (lat=1: first WAIT cycle).
    task automatic do_read(input logic [11:0] val, input int lat, input bit stray_eoc);
        int den_before;
        den_before = den_cnt;
        @(negedge clk);
        eoc_in = 1'b1;
        @(negedge clk);
        eoc_in = 1'b0;
        check("den_pulse", den0, 1);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            eoc_in = stray_eoc && (i == 0);
        end
        drp_drdy = 1'b1;
        drp_do   = {val, 4'($urandom_range(0, 15))};
        push_read(val);
        @(negedge clk);
        drp_drdy = 1'b0;
        eoc_in   = 1'b0;
        drp_do   = 16'($urandom);
        check("sample_valid", sv0, 1);
        check("err_after_read", err0, exp_err);
        check("den_per_read", den_cnt - den_before, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n    = 1'b0;
        eoc_in   = 1'b0;
        drp_drdy = 1'b0;
        drp_do   = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_den", den0, 0);
        check("rst_sample", sample0, 0);
        check("rst_sv", sv0, 0);
        check("rst_level", level2, 0);
        check("rst_lv", lv2, 0);
        check("rst_err", err0, 0);
        check("rst_state", st0, IDLE);
        check("daddr", daddr0, 7'h03);
        check("dwe", dwe0, 0);
        rst_n = 1'b1;

        // averaging block: mean 12'h280 -> level 8'h28
        do_read(12'h100, 1, 1'b0);
        do_read(12'h200, 2, 1'b0);
        do_read(12'h300, 1, 1'b0);
        check("avg_level_hold", level2, 0);
        do_read(12'h400, 3, 1'b0);
        check("avg_level", level2, 8'h28);

        // single read, no averaging
        do_read(12'hABC, 1, 1'b0);
        check("single_level", level0, 8'hAB);
        check("avg_level_holds", level2, 8'h28);

        for (int i = 0; i < 7; i++)
            do_read(12'($urandom), $urandom_range(1, TO - 1), 1'b0);

        // drdy on the terminal timeout cycle wins
        do_read(12'h7E5, TO, 1'b0);
        check("boundary_err0", err0, 0);
        check("boundary_err2", err2, 0);

        // timeout: err appears TIMEOUT+1 cycles after den
        @(negedge clk);
        eoc_in = 1'b1;
        @(negedge clk);
        eoc_in = 1'b0;
        check("to_den", den0, 1);
        repeat (TO) @(negedge clk);
        check("to_err_early", err0, 0);
        check("to_state_wait", st0, WAIT);
        @(negedge clk);
        check("to_err0", err0, 1);
        check("to_err2", err2, 1);
        check("to_state_idle", st0, IDLE);
        exp_err = 1'b1;
        repeat (3) @(negedge clk);
        check("to_sticky", err0, 1);
        do_read(12'h5C3, 2, 1'b0);

        // eoc during WAIT is dropped
        do_read(12'h1F0, 4, 1'b1);
        repeat (2) @(negedge clk);
        check("dropped_eoc_idle", st0, IDLE);

        // stray drdy in IDLE
        @(negedge clk);
        drp_drdy = 1'b1;
        drp_do   = 16'hFFF0;
        @(negedge clk);
        drp_drdy = 1'b0;
        check("stray_drdy_sample", sample0, last_sample);
        check("stray_drdy_sv", sv0, 0);

        // reset mid-WAIT, then late drdy
        @(negedge clk);
        eoc_in = 1'b1;
        @(negedge clk);
        eoc_in = 1'b0;
        @(negedge clk);
        check("midwait_state", st0, WAIT);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        drp_drdy = 1'b1;
        drp_do   = 16'h5A50;
        @(negedge clk);
        drp_drdy = 1'b0;
        acc2 = 0;
        cnt2 = 0;
        last_sample = '0;
        exp_err = 1'b0;
        check("mrst_sample", sample0, 0);
        check("mrst_sv", sv0, 0);
        check("mrst_level0", level0, 0);
        check("mrst_level2", level2, 0);
        check("mrst_err", err0, 0);
        check("mrst_den", den0, 0);
        check("mrst_state", st0, IDLE);

        do_read(12'h3C7, 2, 1'b0);
        check("post_rst_level", level0, 8'h3C);

        repeat (3) @(negedge clk);
        check("s0_q_empty", exp_s0_q.size(), 0);
        check("s2_q_empty", exp_s2_q.size(), 0);
        check("l0_q_empty", exp_l0_q.size(), 0);
        check("l2_q_empty", exp_l2_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
